// File: rtl/enigma_pkg.sv
// rtl/enigma_pkg.sv - shared types, defaults and helpers for the Enigma step controller
package enigma_pkg;
  localparam int LETTER_W    = 5;
  localparam int NUM_LETTERS = 26;
  localparam int NOTCH1      = 16;
  localparam int NOTCH2      = 4;

  typedef logic [LETTER_W-1:0] letter_t;

  typedef enum logic [1:0] {S_IDLE, S_STEP, S_APPLY, S_HOLD} state_t;

  // Wraps the top code back to 0; out-of-range codes also land on 0.
  function automatic letter_t inc_mod26(input letter_t v, input int n = NUM_LETTERS);
    return (int'(v) >= n - 1) ? '0 : v + letter_t'(1);
  endfunction
endpackage

// File: rtl/enigma_rotor_stepper.sv
// rtl/enigma_rotor_stepper.sv - combinational odometer stepping with middle-rotor double step
module enigma_rotor_stepper #(
  parameter int NUM_LETTERS = enigma_pkg::NUM_LETTERS,
  parameter int NOTCH1      = enigma_pkg::NOTCH1,
  parameter int NOTCH2      = enigma_pkg::NOTCH2
) (
  input  logic [enigma_pkg::LETTER_W-1:0] pos1,
  input  logic [enigma_pkg::LETTER_W-1:0] pos2,
  input  logic [enigma_pkg::LETTER_W-1:0] pos3,
  output logic [enigma_pkg::LETTER_W-1:0] next1,
  output logic [enigma_pkg::LETTER_W-1:0] next2,
  output logic [enigma_pkg::LETTER_W-1:0] next3
);
  import enigma_pkg::*;

  logic mid_turn;
  logic slow_turn;

  // The middle rotor at its own notch steps itself along with the slow rotor.
  assign slow_turn = (pos2 == letter_t'(NOTCH2));
  assign mid_turn  = (pos1 == letter_t'(NOTCH1)) || slow_turn;

  assign next1 = inc_mod26(pos1, NUM_LETTERS);
  assign next2 = mid_turn  ? inc_mod26(pos2, NUM_LETTERS) : pos2;
  assign next3 = slow_turn ? inc_mod26(pos3, NUM_LETTERS) : pos3;
endmodule

// File: rtl/enigma_step_controller.sv
// rtl/enigma_step_controller.sv - per-letter sequencer: step rotors, wait on path, present result
module enigma_step_controller #(
  parameter int NUM_LETTERS = enigma_pkg::NUM_LETTERS,
  parameter int NOTCH1      = enigma_pkg::NOTCH1,
  parameter int NOTCH2      = enigma_pkg::NOTCH2,
  parameter int PATH_LAT    = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            load,
  input  logic [enigma_pkg::LETTER_W-1:0] init_pos1,
  input  logic [enigma_pkg::LETTER_W-1:0] init_pos2,
  input  logic [enigma_pkg::LETTER_W-1:0] init_pos3,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [enigma_pkg::LETTER_W-1:0] in_char,
  output logic [enigma_pkg::LETTER_W-1:0] path_char,
  input  logic [enigma_pkg::LETTER_W-1:0] path_result,
  output logic [enigma_pkg::LETTER_W-1:0] rotor1_pos,
  output logic [enigma_pkg::LETTER_W-1:0] rotor2_pos,
  output logic [enigma_pkg::LETTER_W-1:0] rotor3_pos,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [enigma_pkg::LETTER_W-1:0] out_char,
  output logic                            busy,
  output logic                            err
);
  import enigma_pkg::*;

  localparam int CNT_W = (PATH_LAT > 1) ? $clog2(PATH_LAT) : 1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  letter_t          next1, next2, next3;

  function automatic letter_t legal_or_zero(input letter_t v);
    return (int'(v) < NUM_LETTERS) ? v : '0;
  endfunction

  function automatic logic is_illegal(input letter_t v);
    return int'(v) >= NUM_LETTERS;
  endfunction

  enigma_rotor_stepper #(
    .NUM_LETTERS(NUM_LETTERS),
    .NOTCH1     (NOTCH1),
    .NOTCH2     (NOTCH2)
  ) u_stepper (
    .pos1 (rotor1_pos),
    .pos2 (rotor2_pos),
    .pos3 (rotor3_pos),
    .next1(next1),
    .next2(next2),
    .next3(next3)
  );

  // Load has priority, so the letter is refused in the same cycle load is high.
  assign in_ready = (state == S_IDLE) && !load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      rotor1_pos <= '0;
      rotor2_pos <= '0;
      rotor3_pos <= '0;
      path_char  <= '0;
      out_char   <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load) begin
            rotor1_pos <= legal_or_zero(init_pos1);
            rotor2_pos <= legal_or_zero(init_pos2);
            rotor3_pos <= legal_or_zero(init_pos3);
            err        <= is_illegal(init_pos1) || is_illegal(init_pos2) || is_illegal(init_pos3);
          end else if (in_valid) begin
            if (is_illegal(in_char)) begin
              err <= 1'b1;
            end else begin
              path_char <= in_char;
              busy      <= 1'b1;
              state     <= S_STEP;
            end
          end
        end
        S_STEP: begin
          rotor1_pos <= next1;
          rotor2_pos <= next2;
          rotor3_pos <= next3;
          cnt        <= '0;
          state      <= S_APPLY;
        end
        S_APPLY: begin
          if (cnt == CNT_W'(PATH_LAT - 1)) begin
            out_char  <= path_result;
            out_valid <= 1'b1;
            state     <= S_HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_enigma_step_controller.sv
// tb/tb_enigma_step_controller.sv - directed bench with a modulo-add stub rotor path
module tb_enigma_step_controller;
  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [4:0] init_pos1, init_pos2, init_pos3;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_char;
  logic [4:0] path_char;
  logic [4:0] path_result;
  logic [4:0] rotor1_pos, rotor2_pos, rotor3_pos;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_char;
  logic       busy;
  logic       err;

  int tests_run = 0;
  int fails     = 0;

  always #5 clk = ~clk;

  assign path_result = 5'((int'(path_char) + int'(rotor1_pos)) % 26);

  enigma_step_controller #(.PATH_LAT(1)) dut (
    .clk(clk), .rst(rst), .load(load),
    .init_pos1(init_pos1), .init_pos2(init_pos2), .init_pos3(init_pos3),
    .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char),
    .path_char(path_char), .path_result(path_result),
    .rotor1_pos(rotor1_pos), .rotor2_pos(rotor2_pos), .rotor3_pos(rotor3_pos),
    .out_valid(out_valid), .out_ready(out_ready), .out_char(out_char),
    .busy(busy), .err(err)
  );

  function automatic logic [14:0] pos();
    return {rotor1_pos, rotor2_pos, rotor3_pos};
  endfunction

  task automatic do_load(input logic [4:0] p1, input logic [4:0] p2, input logic [4:0] p3);
    @(negedge clk);
    load = 1'b1; init_pos1 = p1; init_pos2 = p2; init_pos3 = p3;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  // Leaves the DUT in HOLD; lat is edges after acceptance until out_valid, -1 on timeout.
  task automatic send_letter(input logic [4:0] ch, output int lat);
    lat = -1;
    @(negedge clk);
    in_valid = 1'b1; in_char = ch; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = i; break; end
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    tests_run++;
    if ({pos(), path_char, out_char} !== 25'd0) begin
      fails++; $display("FAIL reset_regs: got %h want 0", {pos(), path_char, out_char});
    end
    tests_run++;
    if ({in_ready, out_valid, busy, err} !== 4'b1000) begin
      fails++; $display("FAIL reset_flags: got %b want 1000", {in_ready, out_valid, busy, err});
    end
  endtask

  task automatic test_basic();
    int lat;
    do_load(0, 0, 0);
    send_letter(0, lat);
    tests_run++;
    if (lat !== 2) begin fails++; $display("FAIL basic_latency: got %0d want 2", lat); end
    tests_run++;
    if ({pos(), path_char, out_char} !== {5'd1, 5'd0, 5'd0, 5'd0, 5'd1}) begin
      fails++; $display("FAIL basic_result: got %h want %h", {pos(), path_char, out_char}, {5'd1, 5'd0, 5'd0, 5'd0, 5'd1});
    end
    release_out();
  endtask

  task automatic test_notch();
    int lat;
    do_load(16, 0, 0);
    send_letter(7, lat);
    tests_run++;
    if ({pos(), out_char} !== {5'd17, 5'd1, 5'd0, 5'd24}) begin
      fails++; $display("FAIL notch1: got %h want %h", {pos(), out_char}, {5'd17, 5'd1, 5'd0, 5'd24});
    end
    release_out();
    do_load(16, 3, 0);
    send_letter(2, lat);
    tests_run++;
    if (pos() !== {5'd17, 5'd4, 5'd0}) begin
      fails++; $display("FAIL double_step_a: got %h want %h", pos(), {5'd17, 5'd4, 5'd0});
    end
    release_out();
    send_letter(2, lat);
    tests_run++;
    if ({pos(), out_char} !== {5'd18, 5'd5, 5'd1, 5'd20}) begin
      fails++; $display("FAIL double_step_b: got %h want %h", {pos(), out_char}, {5'd18, 5'd5, 5'd1, 5'd20});
    end
    release_out();
  endtask

  task automatic test_wrap();
    int lat;
    do_load(16, 4, 25);
    send_letter(0, lat);
    tests_run++;
    if (pos() !== {5'd17, 5'd5, 5'd0}) begin
      fails++; $display("FAIL wrap_r3: got %h want %h", pos(), {5'd17, 5'd5, 5'd0});
    end
    release_out();
    do_load(25, 0, 0);
    send_letter(3, lat);
    tests_run++;
    if ({pos(), out_char} !== {5'd0, 5'd0, 5'd0, 5'd3}) begin
      fails++; $display("FAIL wrap_r1: got %h want %h", {pos(), out_char}, {5'd0, 5'd0, 5'd0, 5'd3});
    end
    release_out();
  endtask

  task automatic test_hold();
    int lat;
    int bad = 0;
    do_load(2, 0, 0);
    send_letter(10, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if ({out_valid, in_ready, busy, out_char, pos()} !== {3'b101, 5'd13, 5'd3, 5'd0, 5'd0}) bad++;
    end
    tests_run++;
    if (bad !== 0) begin fails++; $display("FAIL hold_stable: got %0d unstable cycles want 0", bad); end
    release_out();
    tests_run++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      fails++; $display("FAIL hold_release: got %b want 010", {out_valid, in_ready, busy});
    end
  endtask

  task automatic test_errors();
    do_load(4, 5, 6);
    @(negedge clk);
    in_valid = 1'b1; in_char = 27;
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests_run++;
    if ({err, busy, out_valid, pos()} !== {3'b100, 5'd4, 5'd5, 5'd6}) begin
      fails++; $display("FAIL bad_letter: got %h want %h", {err, busy, out_valid, pos()}, {3'b100, 5'd4, 5'd5, 5'd6});
    end
    @(posedge clk); #1;
    tests_run++;
    if ({err, busy, out_valid} !== 3'b000) begin
      fails++; $display("FAIL bad_letter_pulse: got %b want 000", {err, busy, out_valid});
    end
    do_load(30, 2, 2);
    tests_run++;
    if ({err, pos()} !== {1'b1, 5'd0, 5'd2, 5'd2}) begin
      fails++; $display("FAIL bad_load: got %h want %h", {err, pos()}, {1'b1, 5'd0, 5'd2, 5'd2});
    end
    @(posedge clk); #1;
    tests_run++;
    if (err !== 1'b0) begin fails++; $display("FAIL bad_load_pulse: got %b want 0", err); end
  endtask

  task automatic test_abort_and_priority();
    int lat;
    do_load(0, 0, 0);
    @(negedge clk);
    in_valid = 1'b1; in_char = 5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({pos(), path_char, out_char, in_ready, out_valid, busy, err} !== {25'd0, 4'b1000}) begin
      fails++; $display("FAIL abort: got %h want %h", {pos(), path_char, out_char, in_ready, out_valid, busy, err}, {25'd0, 4'b1000});
    end
    @(negedge clk);
    rst = 1'b0;
    do_load(0, 0, 0);
    send_letter(0, lat);
    tests_run++;
    if ({lat[4:0], pos(), out_char} !== {5'd2, 5'd1, 5'd0, 5'd0, 5'd1}) begin
      fails++; $display("FAIL after_abort: got %h want %h", {lat[4:0], pos(), out_char}, {5'd2, 5'd1, 5'd0, 5'd0, 5'd1});
    end
    release_out();
    @(negedge clk);
    load = 1'b1; init_pos1 = 3; init_pos2 = 4; init_pos3 = 5;
    in_valid = 1'b1; in_char = 2;
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL load_blocks_ready: got %b want 0", in_ready); end
    @(posedge clk); #1;
    load = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if ({busy, pos()} !== {1'b0, 5'd3, 5'd4, 5'd5}) begin
      fails++; $display("FAIL load_priority: got %h want %h", {busy, pos()}, {1'b0, 5'd3, 5'd4, 5'd5});
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_char = '0; init_pos1 = '0; init_pos2 = '0; init_pos3 = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_basic();
    test_notch();
    test_wrap();
    test_hold();
    test_errors();
    test_abort_and_priority();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
